// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: keypad scanner with debounce, key decode and number-entry buffer; optional KEYPAD_AUTOREPEAT_EN
module keypad_entry_ctrl #(
  parameter int ROWS          = 4,
  parameter int COLS          = 3,
  parameter int NUM_DIGITS    = 2,
  parameter int SCAN_DIV      = 16,
  parameter int DEBOUNCE      = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [COLS-1:0]                   keyboard_cols,
  output logic [ROWS-1:0]                   keyboard_rows,
  output logic                              key_event,
  output logic [3:0]                        key_code,
  output logic [4*NUM_DIGITS-1:0]           cascade_reg,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   num_count,
  output logic                              entry_valid,
  output logic [4*NUM_DIGITS-1:0]           entry_value,
  input  logic                              entry_ready,
  output logic                              start_game,
  output logic                              key_dropped
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int NW = $clog2(NUM_DIGITS + 1);
  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || ROWS * COLS > 16 || NUM_DIGITS < 1 ||
      NUM_DIGITS > 8 || SCAN_DIV < 4 || DEBOUNCE < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("keypad_entry_ctrl: parameter out of range");
  end
  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;
  state_t                  r_state, w_state;
  logic [COLS-1:0]         r_sync, r_scols, w_col_mask;
  logic [RW-1:0]           r_row, w_row, w_row_inc;
  logic [CW-1:0]           r_col, w_col, w_cidx;
  logic [SW-1:0]           r_dwell, w_dwell;
  logic [DW-1:0]           r_db, w_db;
  logic [4:0]              w_k;
  logic [3:0]              w_code, r_key_code;
  logic                    w_accept, w_repeat, w_digit, r_key_event;
  logic [4*NUM_DIGITS-1:0] r_cascade, r_value;
  logic [4*NUM_DIGITS+3:0] w_ext;
  logic [NW-1:0]           r_count;
  logic                    r_valid, r_start, r_drop;
  // Row 0 is the MSB of the row drive and column 0 the MSB of the column sense
  assign keyboard_rows = {1'b1, {(ROWS-1){1'b0}}} >> r_row;
  assign w_col_mask    = {1'b1, {(COLS-1){1'b0}}} >> r_col;
  assign w_row_inc     = (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
  assign w_k           = 5'(r_row) * 5'(COLS) + 5'(r_col);
  assign w_code        = (w_k < 5'd9) ? 4'(w_k + 5'd1) : (w_k == 5'd9) ? 4'hA : (w_k == 5'd10) ? 4'h0 :
                         (w_k == 5'd11) ? 4'hB : w_k[3:0];
  assign w_digit       = (w_code != 4'hA) && (w_code != 4'hB);
  assign w_ext         = {r_cascade, r_key_code};
  assign key_event     = r_key_event;
  assign key_code      = r_key_code;
  assign cascade_reg   = r_cascade;
  assign num_count     = r_count;
  assign entry_valid   = r_valid;
  assign entry_value   = r_value;
  assign start_game    = r_start;
  assign key_dropped   = r_drop;
  // Column index of the single active sense line (only meaningful when one-hot)
  always_comb begin
    w_cidx = '0;
    for (int i = 0; i < COLS; i++) if (r_scols[i]) w_cidx = CW'(COLS - 1 - i);
  end
  // Scan / debounce FSM next-state; rotation always resumes from the row after the latched one
  always_comb begin
    w_state  = r_state;
    w_row    = r_row;
    w_col    = r_col;
    w_dwell  = r_dwell;
    w_db     = r_db;
    w_accept = 1'b0;
    case (r_state)
      SCAN: begin
        if (r_dwell == SW'(SCAN_DIV - 1)) begin
          w_dwell = '0;
          w_db    = '0;
          if ($onehot(r_scols)) begin
            w_state = PRESS_DB;
            w_col   = w_cidx;
          end else w_row = w_row_inc;
        end else w_dwell = r_dwell + 1'b1;
      end
      PRESS_DB: begin
        if (r_scols != w_col_mask) begin
          w_state = SCAN;
          w_row   = w_row_inc;
        end else if (r_db == DW'(DEBOUNCE - 1)) begin
          w_state  = HELD;
          w_accept = 1'b1;
        end else w_db = r_db + 1'b1;
      end
      HELD: begin
        if (r_scols == '0) begin
          w_state = REL_DB;
          w_db    = '0;
        end
      end
      default: begin
        if (r_scols != '0) w_state = HELD;
        else if (r_db == DW'(DEBOUNCE - 1)) begin
          w_state = SCAN;
          w_row   = w_row_inc;
        end else w_db = r_db + 1'b1;
      end
    endcase
  end
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int PW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [PW-1:0] r_rep, w_rep;
  logic          r_first, w_first;
  // Repeat timer runs only while a digit is held; any exit from HELD rearms the initial delay
  always_comb begin
    w_rep    = '0;
    w_first  = 1'b1;
    w_repeat = 1'b0;
    if (r_state == HELD && r_scols != '0 && w_digit) begin
      w_first = r_first;
      if (r_rep == (r_first ? PW'(REPEAT_DELAY - 1) : PW'(REPEAT_PERIOD - 1))) begin
        w_repeat = 1'b1;
        w_first  = 1'b0;
      end else w_rep = r_rep + 1'b1;
    end
  end
  // Repeat timer registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rep   <= '0;
      r_first <= 1'b1;
    end else begin
      r_rep   <= w_rep;
      r_first <= w_first;
    end
  end
`else
  assign w_repeat = 1'b0;
`endif
  // Column synchroniser, FSM state and registered key event
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync      <= '0;
      r_scols     <= '0;
      r_state     <= SCAN;
      r_row       <= '0;
      r_col       <= '0;
      r_dwell     <= '0;
      r_db        <= '0;
      r_key_event <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_sync      <= keyboard_cols;
      r_scols     <= r_sync;
      r_state     <= w_state;
      r_row       <= w_row;
      r_col       <= w_col;
      r_dwell     <= w_dwell;
      r_db        <= w_db;
      r_key_event <= w_accept | w_repeat;
      if (w_accept | w_repeat) r_key_code <= w_code;
    end
  end
  // Entry buffer acts on the registered event; a pending entry blocks every key
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cascade <= '0;
      r_value   <= '0;
      r_count   <= '0;
      r_valid   <= 1'b0;
      r_start   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_drop  <= 1'b0;
      if (r_valid && entry_ready) r_valid <= 1'b0;
      if (r_key_event) begin
        if (r_valid) r_drop <= 1'b1;
        else if (r_key_code == 4'hA) begin
          r_cascade <= '0;
          r_count   <= '0;
        end else if (r_key_code == 4'hB) begin
          if (r_count != '0) begin
            r_value   <= r_cascade;
            r_valid   <= 1'b1;
            r_cascade <= '0;
            r_count   <= '0;
          end else r_start <= 1'b1;
        end else begin
          r_cascade <= w_ext[4*NUM_DIGITS-1:0];
          r_count   <= (r_count == NW'(NUM_DIGITS)) ? r_count : r_count + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed bench for keypad_entry_ctrl (4x3, 2 digits, SCAN_DIV=4, DEBOUNCE=20)
module tb_keypad_entry_ctrl;
  logic       clk = 1'b0, rstn = 1'b0, entry_ready = 1'b0;
  logic [2:0] keyboard_cols;
  logic [3:0] keyboard_rows, key_code;
  logic [7:0] cascade_reg, entry_value;
  logic [1:0] num_count;
  logic       key_event, entry_valid, start_game, key_dropped;
  logic       p_on = 1'b0;
  logic [3:0] p_row = '0;
  logic [2:0] p_col = '0;
  int         checks = 0, errors = 0;
  int         g_ev, g_sg, g_kd;
  logic [3:0] g_code;
  logic       g_frozen;
  logic [3:0] exp_rows [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  always #5 clk = ~clk;

  // Keypad model: a pressed key connects its row drive to its column sense
  assign keyboard_cols = (p_on && (keyboard_rows & p_row) != 4'b0) ? p_col : 3'b000;

  keypad_entry_ctrl #(.ROWS(4), .COLS(3), .NUM_DIGITS(2), .SCAN_DIV(4), .DEBOUNCE(20),
                      .REPEAT_DELAY(100), .REPEAT_PERIOD(50)) dut (
    .clk(clk), .rstn(rstn), .keyboard_cols(keyboard_cols), .keyboard_rows(keyboard_rows),
    .key_event(key_event), .key_code(key_code), .cascade_reg(cascade_reg), .num_count(num_count),
    .entry_valid(entry_valid), .entry_value(entry_value), .entry_ready(entry_ready),
    .start_game(start_game), .key_dropped(key_dropped));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tally();
    if (key_event) begin
      g_ev++;
      g_code = key_code;
    end
    if (start_game) g_sg++;
    if (key_dropped) g_kd++;
  endtask

  task automatic press_key(input logic [3:0] row, input logic [2:0] col, input int hold);
    int n;
    g_ev = 0; g_sg = 0; g_kd = 0; g_code = 'x; g_frozen = 1'b1;
    p_row = row; p_col = col; p_on = 1'b1;
    n = 0;
    while (g_ev == 0 && n < 300) begin
      @(negedge clk);
      n++;
      tally();
    end
    chk("press_accepted", g_ev != 0, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      tally();
      if (keyboard_rows !== row) g_frozen = 1'b0;
    end
    p_on = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tally();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] r0;
    logic changed;
    repeat (5) @(negedge clk);
    chk("rst_rows", keyboard_rows, 4'b1000);
    chk("rst_key_event", key_event, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_cascade", cascade_reg, 0);
    chk("rst_num_count", num_count, 0);
    chk("rst_entry_valid", entry_valid, 0);
    chk("rst_entry_value", entry_value, 0);
    chk("rst_start_game", start_game, 0);
    chk("rst_key_dropped", key_dropped, 0);
    rstn = 1'b1;
    n = 0;
    while (keyboard_rows !== 4'b0100 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_rotation_cycles", n, 4);
    for (int j = 0; j < 16; j++) begin
      chk("scan_rows", keyboard_rows, exp_rows[(1 + j / 4) % 4]);
      @(negedge clk);
    end
    press_key(4'b1000, 3'b100, 10);
    chk("k1_code", g_code, 4'h1);
    chk("k1_events", g_ev, 1);
    chk("k1_rows_frozen", g_frozen, 1);
    press_key(4'b1000, 3'b010, 10);
    chk("k2_code", g_code, 4'h2);
    chk("k2_events", g_ev, 1);
    chk("k2_rows_frozen", g_frozen, 1);
    chk("k12_cascade", cascade_reg, 8'h12);
    chk("k12_count", num_count, 2);
    press_key(4'b1000, 3'b001, 10);
    chk("k3_code", g_code, 4'h3);
    chk("full_cascade", cascade_reg, 8'h23);
    chk("full_count", num_count, 2);
    press_key(4'b0001, 3'b100, 10);
    chk("clr_code", g_code, 4'hA);
    chk("clr_cascade", cascade_reg, 0);
    chk("clr_count", num_count, 0);
    press_key(4'b1000, 3'b100, 5);
    press_key(4'b1000, 3'b010, 5);
    press_key(4'b0001, 3'b001, 5);
    chk("ent_code", g_code, 4'hB);
    chk("ent_valid", entry_valid, 1);
    chk("ent_value", entry_value, 8'h12);
    chk("ent_cascade", cascade_reg, 0);
    chk("ent_count", num_count, 0);
    chk("ent_no_start", g_sg, 0);
    press_key(4'b0100, 3'b010, 5);
    chk("k5_code", g_code, 4'h5);
    chk("k5_dropped", g_kd, 1);
    chk("k5_cascade", cascade_reg, 0);
    chk("k5_count", num_count, 0);
    chk("k5_valid_held", entry_valid, 1);
    chk("k5_value_held", entry_value, 8'h12);
    entry_ready = 1'b1;
    @(negedge clk);
    entry_ready = 1'b0;
    chk("hs_valid_falls", entry_valid, 0);
    press_key(4'b0001, 3'b001, 10);
    chk("sg_events", g_ev, 1);
    chk("sg_pulses", g_sg, 1);
    chk("sg_valid", entry_valid, 0);
    g_ev = 0;
    p_row = 4'b1111; p_col = 3'b010; p_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tally();
    end
    p_on = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tally();
    end
    chk("glitch_no_event", g_ev, 0);
    r0 = keyboard_rows;
    changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (keyboard_rows !== r0) changed = 1'b1;
    end
    chk("glitch_rescan", changed, 1);
    press_key(4'b1000, 3'b100, 5);
    press_key(4'b0001, 3'b001, 5);
    chk("pre_rst_valid", entry_valid, 1);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_valid", entry_valid, 0);
    chk("midrst_rows", keyboard_rows, 4'b1000);
    chk("midrst_key_code", key_code, 0);
    rstn = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
    press_key(4'b0010, 3'b100, 230);
    chk("rep7_events", g_ev, 4);
    chk("rep7_code", g_code, 4'h7);
    chk("rep7_cascade", cascade_reg, 8'h77);
    press_key(4'b0001, 3'b001, 230);
    chk("rep_enter_events", g_ev, 1);
    chk("rep_enter_valid", entry_valid, 1);
    chk("rep_enter_value", entry_value, 8'h77);
`else
    press_key(4'b0010, 3'b100, 230);
    chk("hold7_events", g_ev, 1);
    chk("hold7_cascade", cascade_reg, 8'h07);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
